mem_access_unit: RTL and testbench

- Parametrised MEM-stage load/store unit for the CPU pipeline; successor to the combinational byte-lane controller.
- Generalised to DATA_W of 32 or 64, with a dword size when DATA_W=64.
- Adds: alignment-exception detection, an SRAM-like req/addr_ok/data_ok bus handshake with one outstanding access, pipeline stall generation, and flush/cancel handling.
- Sits between the MEM pipeline register and the data-side bus bridge.

---
 rtl/mem_access_unit_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_align.sv | 59 +++++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE     = 2'd0;
  localparam logic [1:0] MEM_HALFWORD = 2'd1;
  localparam logic [1:0] MEM_WORD     = 2'd2;
  localparam logic [1:0] MEM_DWORD    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus: one request channel plus addr_ok/data_ok acknowledgements.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int NBYTE = DATA_W / 8;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [NBYTE-1:0]  data_wstrb;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// Byte-lane alignment: strobes, lane-shifted store data, extracted/extended load data, misalign flag.
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NBYTE  = DATA_W / 8,
  localparam int OFF_W  = $clog2(NBYTE)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic              signext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_raw,
  output logic [NBYTE-1:0]  strb,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [NBYTE-1:0]  lane_mask;
  logic [DATA_W-1:0] data_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;

  always_comb begin
    lane_mask = '0;
    data_mask = '0;
    sign_bit  = 1'b0;
    misalign  = 1'b0;
    shifted   = rdata_raw >> {off, 3'b000};
    case (size)
      MEM_BYTE: begin
        lane_mask = NBYTE'(1);
        sign_bit  = shifted[7];
      end
      MEM_HALFWORD: begin
        lane_mask = NBYTE'(3);
        sign_bit  = shifted[15];
        misalign  = off[0];
      end
      MEM_WORD: begin
        lane_mask = NBYTE'(15);
        sign_bit  = shifted[31];
        misalign  = |off[1:0];
      end
      default: begin
        // A dword cannot be carried by a 32-bit datapath at all.
        lane_mask = '1;
        sign_bit  = shifted[DATA_W-1];
        misalign  = (DATA_W == 32) ? 1'b1 : |off;
      end
    endcase
    for (int i = 0; i < NBYTE; i++) data_mask[i*8 +: 8] = {8{lane_mask[i]}};
    strb       = lane_mask << off;
    wdata_lane = (wdata & data_mask) << {off, 3'b000};
    rdata_ext  = (shifted & data_mask) | ({DATA_W{signext & sign_bit}} & ~data_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: latches one access, runs the req/addr_ok/data_ok handshake,
// stalls the pipeline while it is in flight and drops the result of flushed accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int NBYTE  = DATA_W / 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid_i,
  input  logic                req_write_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_signext_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic                flush_i,
  input  logic                advance_i,
  output logic                stall_o,
  output logic                adel_o,
  output logic                ades_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                done_o,
  mem_access_unit_if.master   bus
);

  localparam int OFF_W = $clog2(NBYTE);

  state_t            state, state_nxt;
  logic              cancel_p0, cancel_nxt;
  logic              capture;
  logic [ADDR_W-1:0] addr_p0;
  logic [1:0]        size_p0;
  logic              signext_p0;
  logic              write_p0;
  logic [NBYTE-1:0]  strb_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] rdata_p1;

  logic              idle, accept, misalign;
  logic [1:0]        al_size;
  logic [OFF_W-1:0]  al_off;
  logic [NBYTE-1:0]  al_strb;
  logic [DATA_W-1:0] al_wdata, al_rdata;

  // The aligner sees the incoming request while idle and the latched access otherwise.
  assign idle    = (state == S_IDLE);
  assign al_size = idle ? req_size_i : size_p0;
  assign al_off  = idle ? req_addr_i[OFF_W-1:0] : addr_p0[OFF_W-1:0];

  mem_align #(.DATA_W(DATA_W)) u_align (
    .size       (al_size),
    .off        (al_off),
    .signext    (signext_p0),
    .wdata      (req_wdata_i),
    .rdata_raw  (bus.data_rdata),
    .strb       (al_strb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .misalign   (misalign)
  );

  assign accept  = idle & req_valid_i & ~misalign & ~flush_i;
  assign stall_o = accept | (state == S_REQ) | (state == S_WAIT);
  assign adel_o  = idle & req_valid_i & misalign & ~req_write_i;
  assign ades_o  = idle & req_valid_i & misalign & req_write_i;
  assign done_o  = (state == S_DONE);
  assign rdata_o = rdata_p1;

  assign bus.data_req   = (state == S_REQ);
  assign bus.data_wr    = write_p0;
  assign bus.data_size  = size_p0;
  assign bus.data_addr  = addr_p0;
  assign bus.data_wstrb = strb_p0;
  assign bus.data_wdata = wdata_p0;

  always_comb begin
    state_nxt  = state;
    cancel_nxt = cancel_p0;
    capture    = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_REQ;
      S_REQ: begin
        // A request already on the bus is never withdrawn; a flush only marks it cancelled.
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            if (cancel_p0 | flush_i) begin
              state_nxt  = S_IDLE;
              cancel_nxt = 1'b0;
            end else begin
              state_nxt = S_DONE;
              capture   = 1'b1;
            end
          end else if (cancel_p0 | flush_i) begin
            state_nxt  = S_CANCEL;
            cancel_nxt = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (flush_i) begin
          cancel_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.data_data_ok) begin
          if (flush_i) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DONE;
            capture   = 1'b1;
          end
        end else if (flush_i) begin
          state_nxt  = S_CANCEL;
          cancel_nxt = 1'b1;
        end
      end
      S_DONE: if (advance_i | flush_i) state_nxt = S_IDLE;
      S_CANCEL: begin
        if (bus.data_data_ok) begin
          state_nxt  = S_IDLE;
          cancel_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cancel_p0  <= 1'b0;
      addr_p0    <= '0;
      size_p0    <= '0;
      signext_p0 <= 1'b0;
      write_p0   <= 1'b0;
      strb_p0    <= '0;
      wdata_p0   <= '0;
      rdata_p1   <= '0;
    end else begin
      state     <= state_nxt;
      cancel_p0 <= cancel_nxt;
      // p0: request fields latched at acceptance
      if (accept) begin
        addr_p0    <= req_addr_i;
        size_p0    <= req_size_i;
        signext_p0 <= req_signext_i;
        write_p0   <= req_write_i;
        strb_p0    <= req_write_i ? al_strb : '0;
        wdata_p0   <= al_wdata;
      end
      // p1: extracted load result, held through DONE
      if (capture) rdata_p1 <= al_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table-driven accesses on a 32-bit instance with a load-result
// scoreboard, plus hand sequences for flush, reset and a 64-bit instance.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_signext, flush, advance;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, adel, ades, done;
  logic [31:0] rdata;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_size_i(req_size),
    .req_signext_i(req_signext), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .flush_i(flush), .advance_i(advance),
    .stall_o(stall), .adel_o(adel), .ades_o(ades), .rdata_o(rdata), .done_o(done),
    .bus(bus)
  );

  logic        w_valid, w_write, w_signext, w_flush, w_advance;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_stall, w_adel, w_ades, w_done;
  logic [63:0] w_rdata;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid_i(w_valid), .req_write_i(w_write), .req_size_i(w_size),
    .req_signext_i(w_signext), .req_addr_i(w_addr), .req_wdata_i(w_wdata),
    .flush_i(w_flush), .advance_i(w_advance),
    .stall_o(w_stall), .adel_o(w_adel), .ades_o(w_ades), .rdata_o(w_rdata), .done_o(w_done),
    .bus(bus64)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        signext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          dly;
    logic        same;
    int          hold;
    logic        mis;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic se, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] br, int dly, logic same, int hold, logic mis,
                              logic [3:0] ews, logic [31:0] ewd, logic [31:0] erd);
    vec_t v;
    v.write = wr; v.size = sz; v.signext = se; v.addr = a; v.wdata = wd; v.bus_rdata = br;
    v.dly = dly; v.same = same; v.hold = hold; v.mis = mis;
    v.exp_wstrb = ews; v.exp_wdata = ewd; v.exp_rdata = erd;
    return v;
  endfunction

  // Scoreboard: expected load result queued at acceptance, compared when done_o rises.
  logic [31:0] exp_q[$];
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) check("sb_unexpected_done", 64'(done), 64'(0));
      else check("sb_rdata", 64'(rdata), 64'(exp_q.pop_front()));
    end
    done_prev <= done;
  end

  always @(posedge clk) begin
    if (resetn && bus.data_data_ok && (dut.state == S_IDLE || dut.state == S_DONE)) begin
      checks++;
      $display("FAIL protocol: data_ok=%b while state=%0d", bus.data_data_ok, dut.state);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  task automatic do_access(input vec_t v);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = v.write; req_size = v.size; req_signext = v.signext;
    req_addr = v.addr; req_wdata = v.wdata;
    #1;
    if (v.mis) begin
      check("adel", 64'(adel), 64'(!v.write));
      check("ades", 64'(ades), 64'(v.write));
      check("mis_stall", 64'(stall), 64'(0));
      @(posedge clk); #1 req_valid = 1'b0; #1;
      check("mis_no_req", 64'(bus.data_req), 64'(0));
      check("mis_no_stall", 64'(stall), 64'(0));
      return;
    end
    check("accept_stall", 64'(stall), 64'(1));
    exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1 req_valid = 1'b0; req_wdata = '0; #1;
    for (int k = 0; k <= v.dly; k++) begin
      check("req", 64'(bus.data_req), 64'(1));
      check("req_wr", 64'(bus.data_wr), 64'(v.write));
      check("req_size", 64'(bus.data_size), 64'(v.size));
      check("req_addr", 64'(bus.data_addr), 64'(v.addr));
      check("req_wstrb", 64'(bus.data_wstrb), 64'(v.exp_wstrb));
      check("req_wdata", 64'(bus.data_wdata), 64'(v.exp_wdata));
      check("req_stall", 64'(stall), 64'(1));
      if (k < v.dly) begin @(posedge clk); #2; end
    end
    bus.data_addr_ok = 1'b1;
    if (v.same) begin bus.data_data_ok = 1'b1; bus.data_rdata = v.bus_rdata; end
    @(posedge clk); #1 bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; #1;
    if (!v.same) begin
      check("wait_req_low", 64'(bus.data_req), 64'(0));
      check("wait_stall", 64'(stall), 64'(1));
      check("wait_no_done", 64'(done), 64'(0));
      bus.data_data_ok = 1'b1; bus.data_rdata = v.bus_rdata;
      @(posedge clk); #1 bus.data_data_ok = 1'b0; bus.data_rdata = '0; #1;
    end
    check("done", 64'(done), 64'(1));
    check("done_stall", 64'(stall), 64'(0));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #2;
      check("hold_done", 64'(done), 64'(1));
      check("hold_rdata", 64'(rdata), 64'(v.exp_rdata));
    end
    advance = 1'b1;
    @(posedge clk); #1 advance = 1'b0; #1;
    check("after_adv_done", 64'(done), 64'(0));
    check("after_adv_stall", 64'(stall), 64'(0));
  endtask

  initial begin
    vecs[0] = mk(1, MEM_BYTE,     0, 32'h1003, 32'h1234_56A5, 32'h0,         0, 0, 0, 0, 4'b1000, 32'hA500_0000, 32'h0);
    vecs[1] = mk(0, MEM_HALFWORD, 1, 32'h2002, 32'h0,         32'h80FF_1234, 0, 0, 2, 0, 4'b0000, 32'h0,         32'hFFFF_80FF);
    vecs[2] = mk(0, MEM_HALFWORD, 0, 32'h2002, 32'h0,         32'h80FF_1234, 0, 0, 1, 0, 4'b0000, 32'h0,         32'h0000_80FF);
    vecs[3] = mk(0, MEM_WORD,     0, 32'h3001, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[4] = mk(1, MEM_HALFWORD, 0, 32'h3003, 32'hBEEF,      32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[5] = mk(1, MEM_WORD,     0, 32'h3000, 32'hDEAD_BEEF, 32'h0,         3, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    vecs[6] = mk(0, MEM_BYTE,     1, 32'h5001, 32'h0,         32'h0000_8000, 0, 1, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80);
    vecs[7] = mk(1, MEM_HALFWORD, 0, 32'h5002, 32'hFFFF_1234, 32'h0,         1, 0, 0, 0, 4'b1100, 32'h1234_0000, 32'h0);
    vecs[8] = mk(0, MEM_DWORD,    1, 32'h6000, 32'h0,         32'h0,         0, 0, 0, 1, 4'b0000, 32'h0,         32'h0);
    vecs[9] = mk(0, MEM_BYTE,     0, 32'h5003, 32'h0,         32'h9A00_0000, 0, 0, 0, 0, 4'b0000, 32'h0,         32'h0000_009A);

    resetn = 1'b0;
    req_valid = 0; req_write = 0; req_size = 0; req_signext = 0; req_addr = 0; req_wdata = 0;
    flush = 0; advance = 0;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    w_valid = 0; w_write = 0; w_size = 0; w_signext = 0; w_addr = 0; w_wdata = 0;
    w_flush = 0; w_advance = 0;
    bus64.data_addr_ok = 0; bus64.data_data_ok = 0; bus64.data_rdata = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1; #1;
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_req", 64'(bus.data_req), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wstrb", 64'(bus.data_wstrb), 64'(0));

    for (int i = 0; i < 10; i++) do_access(vecs[i]);

    // Flush while the request is waiting for addr_ok.
    @(posedge clk); #1 req_valid = 1; req_write = 0; req_size = MEM_WORD; req_addr = 32'h4000; #1;
    check("fr_accept_stall", 64'(stall), 64'(1));
    @(posedge clk); #1 req_valid = 0; flush = 1; #1;
    check("fr_req", 64'(bus.data_req), 64'(1));
    @(posedge clk); #1 flush = 0; #1;
    check("fr_req_held", 64'(bus.data_req), 64'(1));
    check("fr_stall_held", 64'(stall), 64'(1));
    bus.data_addr_ok = 1;
    @(posedge clk); #1 bus.data_addr_ok = 0; #1;
    check("fr_cancel_req", 64'(bus.data_req), 64'(0));
    check("fr_cancel_stall", 64'(stall), 64'(0));
    check("fr_cancel_done", 64'(done), 64'(0));
    bus.data_data_ok = 1; bus.data_rdata = 32'h5555_5555;
    @(posedge clk); #1 bus.data_data_ok = 0; bus.data_rdata = 0; #1;
    check("fr_idle_done", 64'(done), 64'(0));
    check("fr_idle_stall", 64'(stall), 64'(0));
    check("fr_rdata_kept", 64'(rdata), 64'(32'h9A));

    // Flush while waiting for data_ok.
    @(posedge clk); #1 req_valid = 1; req_addr = 32'h4004; #1;
    @(posedge clk); #1 req_valid = 0; bus.data_addr_ok = 1; #1;
    check("fw_req", 64'(bus.data_req), 64'(1));
    @(posedge clk); #1 bus.data_addr_ok = 0; flush = 1; #1;
    check("fw_wait_stall", 64'(stall), 64'(1));
    @(posedge clk); #1 flush = 0; #1;
    check("fw_cancel_stall", 64'(stall), 64'(0));
    check("fw_cancel_done", 64'(done), 64'(0));
    bus.data_data_ok = 1; bus.data_rdata = 32'h6666_6666;
    @(posedge clk); #1 bus.data_data_ok = 0; bus.data_rdata = 0; #1;
    check("fw_idle_done", 64'(done), 64'(0));
    check("fw_idle_req", 64'(bus.data_req), 64'(0));

    // Flush in IDLE blocks acceptance of a legal request.
    @(posedge clk); #1 req_valid = 1; flush = 1; req_addr = 32'h4008; #1;
    check("fi_stall", 64'(stall), 64'(0));
    @(posedge clk); #1 req_valid = 0; flush = 0; #1;
    check("fi_no_req", 64'(bus.data_req), 64'(0));

    // Asynchronous reset in the middle of WAIT.
    @(posedge clk); #1 req_valid = 1; req_write = 1; req_size = MEM_BYTE; req_addr = 32'h7001; req_wdata = 32'h77; #1;
    @(posedge clk); #1 req_valid = 0; bus.data_addr_ok = 1; #1;
    @(posedge clk); #1 bus.data_addr_ok = 0; #1;
    check("rw_wait_stall", 64'(stall), 64'(1));
    resetn = 0; #1;
    check("rw_stall", 64'(stall), 64'(0));
    check("rw_req", 64'(bus.data_req), 64'(0));
    check("rw_done", 64'(done), 64'(0));
    check("rw_rdata", 64'(rdata), 64'(0));
    check("rw_addr", 64'(bus.data_addr), 64'(0));
    check("rw_wstrb", 64'(bus.data_wstrb), 64'(0));
    check("rw_wdata", 64'(bus.data_wdata), 64'(0));
    check("rw_wr", 64'(bus.data_wr), 64'(0));
    @(posedge clk); #1 resetn = 1; req_write = 0; req_wdata = 0;

    // 64-bit instance: dword load with addr_ok and data_ok in the same cycle.
    @(posedge clk); #1 w_valid = 1; w_size = MEM_DWORD; w_signext = 1; w_addr = 32'h10; #1;
    check("w_accept_stall", 64'(w_stall), 64'(1));
    check("w_no_adel", 64'(w_adel), 64'(0));
    @(posedge clk); #1 w_valid = 0; #1;
    check("w_req", 64'(bus64.data_req), 64'(1));
    check("w_size", 64'(bus64.data_size), 64'(3));
    check("w_wstrb", 64'(bus64.data_wstrb), 64'(0));
    bus64.data_addr_ok = 1; bus64.data_data_ok = 1; bus64.data_rdata = 64'hF123_4567_89AB_CDEF;
    @(posedge clk); #1 bus64.data_addr_ok = 0; bus64.data_data_ok = 0; bus64.data_rdata = 0; #1;
    check("w_done", 64'(w_done), 64'(1));
    check("w_rdata", w_rdata, 64'hF123_4567_89AB_CDEF);
    check("w_done_stall", 64'(w_stall), 64'(0));
    w_advance = 1;
    @(posedge clk); #1 w_advance = 0; #1;
    check("w_after_adv", 64'(w_done), 64'(0));

    // 64-bit: misaligned dword, then signed word from the upper lane.
    @(posedge clk); #1 w_valid = 1; w_addr = 32'h14; #1;
    check("w_mis_adel", 64'(w_adel), 64'(1));
    check("w_mis_stall", 64'(w_stall), 64'(0));
    w_size = MEM_WORD; #1;
    check("w_word_ok", 64'(w_adel), 64'(0));
    @(posedge clk); #1 w_valid = 0; #1;
    check("w_word_req", 64'(bus64.data_req), 64'(1));
    bus64.data_addr_ok = 1;
    @(posedge clk); #1 bus64.data_addr_ok = 0; bus64.data_data_ok = 1;
    bus64.data_rdata = 64'h8000_0001_1234_5678;
    @(posedge clk); #1 bus64.data_data_ok = 0; bus64.data_rdata = 0; #1;
    check("w_word_done", 64'(w_done), 64'(1));
    check("w_word_rdata", w_rdata, 64'hFFFF_FFFF_8000_0001);
    w_advance = 1;
    @(posedge clk); #1 w_advance = 0;

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
